// File: rtl/hazard_controller.sv
// hazard_controller: detects load-use and branch-operand hazards in ID,
// inserts one or two bubbles, flushes IF/ID on taken branches, freezes the
// pipeline while data memory is busy, and keeps saturating event counters
// plus a sticky memory-timeout flag.
module hazard_controller #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IF_ID_Rs1_i,
   input  logic [4:0]       IF_ID_Rs2_i,
   input  logic             branch_i,
   input  logic             branch_taken_i,
   input  logic [4:0]       ID_EX_Rd_i,
   input  logic             ID_EX_MemRead_i,
   input  logic             ID_EX_RegWrite_i,
   input  logic             mem_stall_i,
   input  logic             clear_i,
   output logic             stall_o,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             freeze_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] bubble_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] freeze_cnt_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   typedef enum logic {
      RUN     = 1'b0,
      BUBBLE2 = 1'b1
   } stateT;

   stateT             state;
   stateT             nextState;
   logic              rdMatch;
   logic              loadUse;
   logic              branchAlu;
   logic [WAIT_W-1:0] waitCnt;

   // The EX destination only counts as a producer when it is not x0 and
   // matches one of the ID source registers.
   always_comb begin
      rdMatch   = (ID_EX_Rd_i != 5'd0) &&
                  ((ID_EX_Rd_i == IF_ID_Rs1_i) || (ID_EX_Rd_i == IF_ID_Rs2_i));
      loadUse   = ID_EX_MemRead_i && rdMatch;
      branchAlu = branch_i && ID_EX_RegWrite_i && !ID_EX_MemRead_i && rdMatch;
   end

   // State register; an asynchronous reset drops any pending second bubble.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   // Next state and pipeline controls: a memory freeze overrides everything,
   // then the pending bubble, then a fresh hazard, then a taken-branch flush.
   always_comb begin
      nextState     = state;
      stall_o       = 1'b0;
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
      if_id_flush_o = 1'b0;
      freeze_o      = 1'b0;
      if (mem_stall_i) begin
         freeze_o      = 1'b1;
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (loadUse || branchAlu) begin
                  stall_o       = 1'b1;
                  pc_write_o    = 1'b0;
                  if_id_write_o = 1'b0;
                  if (loadUse && branch_i) begin
                     nextState = BUBBLE2;
                  end
               end else begin
                  if_id_flush_o = branch_i && branch_taken_i;
               end
            end
            BUBBLE2: begin
               stall_o       = 1'b1;
               pc_write_o    = 1'b0;
               if_id_write_o = 1'b0;
               nextState     = RUN;
            end
            default: begin
               nextState = RUN;
            end
         endcase
      end
   end

   // Saturating event counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_o <= '0;
         flush_cnt_o  <= '0;
         freeze_cnt_o <= '0;
      end else if (clear_i) begin
         bubble_cnt_o <= '0;
         flush_cnt_o  <= '0;
         freeze_cnt_o <= '0;
      end else begin
         if (stall_o && (bubble_cnt_o != CNT_MAX)) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
         end
         if (if_id_flush_o && (flush_cnt_o != CNT_MAX)) begin
            flush_cnt_o <= flush_cnt_o + CNT_ONE;
         end
         if (freeze_o && (freeze_cnt_o != CNT_MAX)) begin
            freeze_cnt_o <= freeze_cnt_o + CNT_ONE;
         end
      end
   end

   // Run length of consecutive memory-busy cycles, held at TIMEOUT once
   // reached; clear does not touch it so an ongoing stall keeps counting.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         waitCnt <= '0;
      end else if (!mem_stall_i) begin
         waitCnt <= '0;
      end else if (waitCnt != WAIT_MAX) begin
         waitCnt <= waitCnt + WAIT_ONE;
      end
   end

   // Sticky timeout flag raised on the TIMEOUT-th consecutive busy cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         timeout_o <= 1'b0;
      end else if (clear_i) begin
         timeout_o <= 1'b0;
      end else if (mem_stall_i && (waitCnt == WAIT_LAST)) begin
         timeout_o <= 1'b1;
      end
   end

endmodule
